// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package rf_pkg;

  localparam int unsigned ZERO_REG        = 0;
  localparam int unsigned PC_STEP_DEFAULT = 4;
  localparam int unsigned NREGS_MAX       = 32;

  // Scoreboard storage is sized for the largest supported register count.
  typedef logic [NREGS_MAX-1:0] sb_vec_t;

  // Address width that never collapses to zero bits.
  function automatic int unsigned aw_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback or link, frozen on halt.
module rf_scoreboard import rf_pkg::*; #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = aw_of(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halt_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic              clr_a_en_i,
  input  logic [AW-1:0]     clr_a_addr_i,
  input  logic              clr_b_en_i,
  input  logic [AW-1:0]     clr_b_addr_i,
  input  logic [NRD*AW-1:0] lookup_addr_i,
  output logic [NRD-1:0]    busy_o
);

  sb_vec_t busy_q, busy_d;

  // Clears first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_a_en_i) busy_d[clr_a_addr_i] = 1'b0;
    if (clr_b_en_i) busy_d[clr_b_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != AW'(ZERO_REG))) busy_d[set_addr_i] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else if (!halt_i) begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      busy_o[i] = busy_q[lookup_addr_i[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised CPU register file: NRD read ports with optional bypass, writeback and
// link write ports, program counter and busy scoreboard.
module reg_file_mp import rf_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter int unsigned     NRD      = 2,
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              BYPASS   = 1'b1,
  localparam int unsigned    AW       = aw_of(NREGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  halt_i,
  input  logic [NRD*AW-1:0]     rd_addr_i,
  output logic [NRD*XLEN-1:0]   rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  wb_en_i,
  input  logic [AW-1:0]         wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  pc_load_i,
  input  logic [XLEN-1:0]       pc_load_val_i,
  input  logic [AW-1:0]         link_addr_i,
  input  logic                  pc_freeze_i,
  input  logic                  issue_en_i,
  input  logic [AW-1:0]         issue_rd_i,
  output logic                  wr_collision_o,
  output logic [XLEN-1:0]       pc_out_o,
  output logic [NREGS*XLEN-1:0] reg_dump_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] pc_q, pc_d, link_val;
  logic            commit, link_we, wb_we, collision, wr_collision_q;

  assign commit    = !rst_i && !halt_i;
  assign link_val  = pc_q + XLEN'(PC_STEP);
  assign link_we   = commit && pc_load_i && (link_addr_i != AW'(ZERO_REG));
  assign collision = link_we && wb_en_i && (wb_addr_i == link_addr_i);
  assign wb_we     = commit && wb_en_i && (wb_addr_i != AW'(ZERO_REG)) && !collision;

  always_comb begin
    pc_d = pc_q + XLEN'(PC_STEP);
    if (pc_load_i) begin
      pc_d = pc_load_val_i;
    end else if (pc_freeze_i) begin
      pc_d = pc_q;
    end
  end

  // x0 is never a write target, so its reset value of zero persists.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q           <= RESET_PC;
      wr_collision_q <= 1'b0;
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      wr_collision_q <= collision;
      if (!halt_i) pc_q <= pc_d;
      if (wb_we) regs_q[wb_addr_i] <= wb_data_i;
      if (link_we) regs_q[link_addr_i] <= link_val;
    end
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;

  // Link is checked after writeback so a colliding link value is what gets forwarded.
  always_comb begin
    rd_data_o = '0;
    ra        = '0;
    rv        = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr_i[i*AW +: AW];
      rv = regs_q[ra];
      if (BYPASS && wb_we && (ra == wb_addr_i)) rv = wb_data_i;
      if (BYPASS && link_we && (ra == link_addr_i)) rv = link_val;
      if (ra == AW'(ZERO_REG)) rv = '0;
      rd_data_o[i*XLEN +: XLEN] = rv;
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_dump
    assign reg_dump_o[r*XLEN +: XLEN] = regs_q[r];
  end

  assign pc_out_o       = pc_q;
  assign wr_collision_o = wr_collision_q;

  rf_scoreboard #(
    .NREGS(NREGS),
    .NRD  (NRD),
    .AW   (AW)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .halt_i       (halt_i),
    .set_en_i     (issue_en_i),
    .set_addr_i   (issue_rd_i),
    .clr_a_en_i   (wb_en_i),
    .clr_a_addr_i (wb_addr_i),
    .clr_b_en_i   (pc_load_i),
    .clr_b_addr_i (link_addr_i),
    .lookup_addr_i(rd_addr_i),
    .busy_o       (rd_busy_o)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: one bypassing and one non-bypassing instance share stimulus and
// are compared every cycle against an architectural model, plus directed literal checks.
module tb_reg_file_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;
  localparam logic [31:0] RST_PC = 32'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, halt, wb_en, pc_load, pc_freeze, issue_en;
  logic [NRD*AW-1:0]     rd_addr;
  logic [AW-1:0]         wb_addr, link_addr, issue_rd;
  logic [XLEN-1:0]       wb_data, pc_load_val;

  logic [NRD*XLEN-1:0]   rd_b, rd_n;
  logic [NRD-1:0]        busy_b, busy_n;
  logic                  coll_b, coll_n;
  logic [XLEN-1:0]       pc_b, pc_n;
  logic [NREGS*XLEN-1:0] dump_b, dump_n;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PC_STEP(4), .RESET_PC(RST_PC),
                .BYPASS(1'b1)) u_dut_byp (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .rd_addr_i(rd_addr), .rd_data_o(rd_b),
    .rd_busy_o(busy_b), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .pc_load_i(pc_load), .pc_load_val_i(pc_load_val), .link_addr_i(link_addr),
    .pc_freeze_i(pc_freeze), .issue_en_i(issue_en), .issue_rd_i(issue_rd),
    .wr_collision_o(coll_b), .pc_out_o(pc_b), .reg_dump_o(dump_b)
  );

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PC_STEP(4), .RESET_PC(RST_PC),
                .BYPASS(1'b0)) u_dut_nob (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .rd_addr_i(rd_addr), .rd_data_o(rd_n),
    .rd_busy_o(busy_n), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .pc_load_i(pc_load), .pc_load_val_i(pc_load_val), .link_addr_i(link_addr),
    .pc_freeze_i(pc_freeze), .issue_en_i(issue_en), .issue_rd_i(issue_rd),
    .wr_collision_o(coll_n), .pc_out_o(pc_n), .reg_dump_o(dump_n)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_pc;
  bit          m_busy [NREGS];
  bit          m_coll;

  always @(posedge clk) begin
    bit linking, drop;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = 0;
        m_busy[r] = 0;
      end
      m_pc   = RST_PC;
      m_coll = 0;
    end else if (halt) begin
      m_coll = 0;
    end else begin
      linking = pc_load && (link_addr != 0);
      drop    = wb_en && linking && (wb_addr == link_addr);
      m_coll  = drop;
      if (wb_en && wb_addr != 0 && !drop) m_regs[wb_addr] = wb_data;
      if (linking) m_regs[link_addr] = m_pc + 32'd4;
      if (wb_en) m_busy[wb_addr] = 0;
      if (linking) m_busy[link_addr] = 0;
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
      if (pc_load) m_pc = pc_load_val;
      else if (!pc_freeze) m_pc = m_pc + 32'd4;
    end
  end

  function automatic logic [31:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && !rst && !halt) begin
      if (pc_load && link_addr != 0 && a == link_addr) return m_pc + 32'd4;
      if (wb_en && a == wb_addr) return wb_data;
    end
    return m_regs[a];
  endfunction

  function automatic logic [31:0] reg_of(input logic [NREGS*XLEN-1:0] d, input int r);
    return d[r*XLEN +: XLEN];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [AW-1:0] a;
      check("pc_byp", pc_b, m_pc);
      check("pc_nob", pc_n, m_pc);
      check("coll_byp", {31'd0, coll_b}, {31'd0, m_coll});
      check("coll_nob", {31'd0, coll_n}, {31'd0, m_coll});
      for (int i = 0; i < NRD; i++) begin
        a = rd_addr[i*AW +: AW];
        check($sformatf("rd%0d_byp", i), rd_b[i*XLEN +: XLEN], exp_read(a, 1'b1));
        check($sformatf("rd%0d_nob", i), rd_n[i*XLEN +: XLEN], exp_read(a, 1'b0));
        check($sformatf("busy%0d_byp", i), {31'd0, busy_b[i]}, {31'd0, m_busy[a]});
        check($sformatf("busy%0d_nob", i), {31'd0, busy_n[i]}, {31'd0, m_busy[a]});
      end
      for (int r = 0; r < NREGS; r++) begin
        check($sformatf("dump_byp_x%0d", r), reg_of(dump_b, r), m_regs[r]);
        check($sformatf("dump_nob_x%0d", r), reg_of(dump_n, r), m_regs[r]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; halt = 0; wb_en = 0; pc_load = 0; pc_freeze = 0; issue_en = 0;
    wb_addr = 0; link_addr = 0; issue_rd = 0; wb_data = 0; pc_load_val = 0; rd_addr = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk_en = 1;

    // Free-running PC out of reset
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check($sformatf("reset_pc%0d", k), pc_b, RST_PC + 32'(4 * k));
      check("reset_busy", {30'd0, busy_b}, 32'd0);
      check("reset_x5", reg_of(dump_b, 5), 32'd0);
      tick();
    end

    // Writeback with same-cycle read
    pc_freeze = 1;
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    at_neg();
    check("wb_bypass_same", rd_b[31:0], 32'hDEADBEEF);
    check("wb_nobypass_same", rd_n[31:0], 32'd0);
    tick();
    wb_en = 0;
    at_neg();
    check("wb_nobypass_next", rd_n[31:0], 32'hDEADBEEF);
    wb_en = 1; wb_addr = 0; wb_data = 32'h12345678; rd_addr = 0;
    at_neg();
    check("wb_x0_byp", rd_b[31:0], 32'd0);
    tick();
    wb_en = 0;
    at_neg();
    check("wb_x0_after", rd_n[31:0], 32'd0);

    // Link/writeback collision
    pc_freeze = 0; pc_load = 1; pc_load_val = 32'h200;
    tick();
    pc_load_val = 32'h400; link_addr = 1;
    wb_en = 1; wb_addr = 1; wb_data = 32'h55; rd_addr = {5'd1, 5'd0};
    at_neg();
    check("coll_pc_before", pc_b, 32'h200);
    check("coll_fwd_link", rd_b[63:32], 32'h204);
    tick();
    idle(); pc_freeze = 1;
    at_neg();
    check("coll_pc_after", pc_b, 32'h400);
    check("coll_x1", reg_of(dump_b, 1), 32'h204);
    check("coll_pulse", {31'd0, coll_b}, 32'd1);
    tick();
    at_neg();
    check("coll_pulse_end", {31'd0, coll_b}, 32'd0);

    // Scoreboard sequence
    issue_en = 1; issue_rd = 7; rd_addr = {5'd0, 5'd7};
    tick();
    at_neg();
    check("sb_set", {31'd0, busy_b[0]}, 32'd1);
    wb_en = 1; wb_addr = 7; wb_data = 32'h77;
    tick();
    at_neg();
    check("sb_set_wins", {31'd0, busy_b[0]}, 32'd1);
    issue_en = 0;
    tick();
    wb_en = 0;
    at_neg();
    check("sb_clear", {31'd0, busy_b[0]}, 32'd0);
    issue_en = 1; issue_rd = 0; rd_addr = 0;
    tick();
    issue_en = 0;
    at_neg();
    check("sb_x0", {31'd0, busy_b[0]}, 32'd0);

    // Halt freezes everything
    issue_en = 1; issue_rd = 9; pc_freeze = 0; pc_load = 1; pc_load_val = 32'h300;
    tick();
    idle();
    halt = 1; wb_en = 1; wb_addr = 9; wb_data = 32'h99; pc_load = 1; pc_load_val = 32'h800;
    link_addr = 2; issue_en = 1; issue_rd = 10; rd_addr = {5'd10, 5'd9};
    at_neg();
    check("halt_no_fwd", rd_b[31:0], 32'd0);
    tick();
    idle(); rd_addr = {5'd10, 5'd9};
    at_neg();
    check("halt_pc", pc_b, 32'h300);
    check("halt_busy9", {31'd0, busy_b[0]}, 32'd1);
    check("halt_busy10", {31'd0, busy_b[1]}, 32'd0);
    check("halt_x9", reg_of(dump_b, 9), 32'd0);
    check("halt_x2", reg_of(dump_b, 2), 32'd0);
    tick();
    at_neg();
    check("halt_resume", pc_b, 32'h304);

    // Reset overrides halt and pc_load
    wb_en = 1; wb_addr = 4; wb_data = 32'h44; issue_en = 1; issue_rd = 4;
    tick();
    idle();
    rst = 1; halt = 1; pc_load = 1; pc_load_val = 32'h900;
    tick();
    idle(); pc_freeze = 1; rd_addr = {5'd0, 5'd4};
    at_neg();
    check("rst_pc", pc_b, RST_PC);
    check("rst_x4", reg_of(dump_b, 4), 32'd0);
    check("rst_busy4", {31'd0, busy_b[0]}, 32'd0);

    // PC wrap, and link value wrap
    pc_freeze = 0; pc_load = 1; pc_load_val = 32'hFFFF_FFFC;
    tick();
    idle();
    at_neg();
    check("wrap_pre", pc_b, 32'hFFFF_FFFC);
    tick();
    at_neg();
    check("wrap_post", pc_b, 32'h0000_0000);
    pc_load = 1; pc_load_val = 32'hFFFF_FFFC;
    tick();
    pc_load_val = 32'h500; link_addr = 3;
    tick();
    idle();
    at_neg();
    check("link_wrap_x3", reg_of(dump_b, 3), 32'h0);
    check("link_wrap_pc", pc_b, 32'h500);

    // Randomised traffic, biased toward low addresses to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      halt        = ($urandom_range(0, 7) == 0);
      wb_en       = $urandom_range(0, 1);
      wb_addr     = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wb_data     = $urandom;
      pc_load     = ($urandom_range(0, 3) == 0);
      pc_load_val = $urandom;
      link_addr   = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      pc_freeze   = ($urandom_range(0, 3) == 0);
      issue_en    = $urandom_range(0, 1);
      issue_rd    = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      rd_addr     = {($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom),
                     ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom)};
      tick();
    end
    idle();
    at_neg();
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
